regarray_access_scheduler: RTL and testbench

Owns an NUM-entry x DSIZE register array and shares it between two requester ports (A, B) through a round-robin arbiter. A range-clear sweep engine zeroes a contiguous entry range, one entry per cycle, on command. It sits between datapath producers/consumers and the array. It replaces ad-hoc combinational clear loops with a sequenced, arbitrated clear.

---
 rtl/regarray_access_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_regarray_access_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regarray_access_scheduler.sv
// regarray_access_scheduler
//   Owns a NUM x DSIZE register array shared by two requester ports (A, B)
//   through a round-robin arbiter, plus a range-clear sweep engine that zeroes
//   entries clr_lo..clr_hi, one per cycle, with the array locked out meanwhile.
//
// Ports
//   clock, rst_n                 clock (rising edge), async active-low reset
//   a_* / b_*                    requester ports: valid/ready handshake, wr
//                                select, entry address, write data, registered
//                                read data and one-cycle read-valid pulse
//   clr_start, clr_lo, clr_hi    sweep command and inclusive entry range
//   clr_busy                     sweep in progress
//   clr_done                     sweep finished (one-cycle pulse)
//   clr_err                      bounds rejected, pulses together with clr_done
module regarray_access_scheduler #(
    parameter int NUM   = 32,
    parameter int DSIZE = 32,
    localparam int AW   = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic             clock,
    input  logic             rst_n,

    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_wr,
    input  logic [AW-1:0]    a_addr,
    input  logic [DSIZE-1:0] a_wdata,
    output logic [DSIZE-1:0] a_rdata,
    output logic             a_rvalid,

    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_wr,
    input  logic [AW-1:0]    b_addr,
    input  logic [DSIZE-1:0] b_wdata,
    output logic [DSIZE-1:0] b_rdata,
    output logic             b_rvalid,

    input  logic             clr_start,
    input  logic [AW-1:0]    clr_lo,
    input  logic [AW-1:0]    clr_hi,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             clr_err
);

    // One bit wider than an address so NUM itself is representable.
    localparam logic [AW:0] NUM_W = (AW + 1)'(NUM);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    hi_q;
    logic             clr_busy_q;
    logic             clr_done_q;
    logic             clr_err_q;

    logic             prefer_a_q;
    logic             prefer_a_d;

    logic [DSIZE-1:0] mem_q [NUM];

    logic [DSIZE-1:0] a_rdata_q;
    logic [DSIZE-1:0] b_rdata_q;
    logic             a_rvalid_q;
    logic             b_rvalid_q;

    logic             arb_en;
    logic             gnt_a;
    logic             gnt_b;
    logic             acc_wr;
    logic [AW-1:0]    acc_addr;
    logic [DSIZE-1:0] acc_wdata;
    logic             acc_in_rng;
    logic [DSIZE-1:0] acc_rdata;
    logic             bounds_ok;

    // ------------------------------------------------------------------
    // Arbitration: combinational grant, frozen while the sweep owns the array.
    // prefer_a_q records which side wins a tie (the one not granted last).
    // ------------------------------------------------------------------
    always_comb begin
        arb_en = (state_q != SWEEP);
        gnt_a  = arb_en && a_valid && (!b_valid || prefer_a_q);
        gnt_b  = arb_en && b_valid && !gnt_a;

        prefer_a_d = prefer_a_q;
        if (gnt_a) begin
            prefer_a_d = 1'b0;
        end else if (gnt_b) begin
            prefer_a_d = 1'b1;
        end
    end

    // Single shared access path: at most one of gnt_a/gnt_b is set.
    always_comb begin
        acc_wr     = gnt_b ? b_wr    : a_wr;
        acc_addr   = gnt_b ? b_addr  : a_addr;
        acc_wdata  = gnt_b ? b_wdata : a_wdata;
        acc_in_rng = ({1'b0, acc_addr} < NUM_W);
        acc_rdata  = '0;
        if (acc_in_rng) begin
            acc_rdata = mem_q[acc_addr];
        end
    end

    always_comb begin
        bounds_ok = (clr_lo <= clr_hi) && ({1'b0, clr_hi} < NUM_W);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            prefer_a_q <= 1'b1;
        end else begin
            prefer_a_q <= prefer_a_d;
        end
    end

    // ------------------------------------------------------------------
    // Register array. Sweep writes and port writes never coincide because
    // grants are blocked during SWEEP; out-of-range writes are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (state_q == SWEEP) begin
            mem_q[idx_q] <= '0;
        end else if ((gnt_a || gnt_b) && acc_wr && acc_in_rng) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read return: data registered on accept, held until the next read on
    // the same port; rvalid is a one-cycle pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= gnt_a && !a_wr;
            b_rvalid_q <= gnt_b && !b_wr;
            if (gnt_a && !a_wr) begin
                a_rdata_q <= acc_rdata;
            end
            if (gnt_b && !b_wr) begin
                b_rdata_q <= acc_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Range-clear FSM with registered status outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hi_q       <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            clr_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        if (bounds_ok) begin
                            state_q    <= SWEEP;
                            idx_q      <= clr_lo;
                            hi_q       <= clr_hi;
                            clr_busy_q <= 1'b1;
                        end else begin
                            state_q    <= DONE;
                            clr_done_q <= 1'b1;
                            clr_err_q  <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (idx_q == hi_q) begin
                        state_q    <= DONE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                        clr_err_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    clr_done_q <= 1'b0;
                    clr_err_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                    clr_err_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_ready  = gnt_a;
    assign b_ready  = gnt_b;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;
    assign clr_err  = clr_err_q;

endmodule

// File: tb/tb_regarray_access_scheduler.sv
// Bench for regarray_access_scheduler: directed steps plus random traffic,
// checked against a transaction-level model of the array, arbiter and sweep.
module tb_regarray_access_scheduler;

    localparam int NUM   = 32;
    localparam int DSIZE = 32;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid, a_ready, a_wr, a_rvalid;
    logic [4:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_valid, b_ready, b_wr, b_rvalid;
    logic [4:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic        clr_start, clr_busy, clr_done, clr_err;
    logic [4:0]  clr_lo, clr_hi;

    always #5 clock = ~clock;

    regarray_access_scheduler #(.NUM(NUM), .DSIZE(DSIZE)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_wr     (a_wr),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_wr     (b_wr),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid),
        .clr_start(clr_start),
        .clr_lo   (clr_lo),
        .clr_hi   (clr_hi),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_err  (clr_err)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned fails  = 0;

    // Reference model: array contents, tie-break owner, last read data per port.
    logic [31:0] mem_m [NUM];
    logic        last_b_m;
    logic [31:0] ard_m, brd_m;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) mem_m[i] = '0;
        last_b_m = 1'b1;
        ard_m    = '0;
        brd_m    = '0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_a_ready"},  {31'd0, a_ready},  32'd0);
        chk({tag, "_b_ready"},  {31'd0, b_ready},  32'd0);
        chk({tag, "_a_rvalid"}, {31'd0, a_rvalid}, 32'd0);
        chk({tag, "_b_rvalid"}, {31'd0, b_rvalid}, 32'd0);
        chk({tag, "_a_rdata"},  a_rdata,           32'd0);
        chk({tag, "_b_rdata"},  b_rdata,           32'd0);
        chk({tag, "_busy"},     {31'd0, clr_busy}, 32'd0);
        chk({tag, "_done"},     {31'd0, clr_done}, 32'd0);
        chk({tag, "_err"},      {31'd0, clr_err},  32'd0);
    endtask

    // One arbitrated cycle outside a sweep, checked against the model.
    task automatic drive_cycle(input logic av, input logic aw, input logic [4:0] aad,
                               input logic [31:0] ad, input logic bv, input logic bw,
                               input logic [4:0] bad, input logic [31:0] bd,
                               output logic got_a, output logic got_b);
        logic ga, gb;
        a_valid = av; a_wr = aw; a_addr = aad; a_wdata = ad;
        b_valid = bv; b_wr = bw; b_addr = bad; b_wdata = bd;
        #1;
        ga = av && (!bv || last_b_m);
        gb = bv && !ga;
        got_a = a_ready;
        got_b = b_ready;
        chk("a_ready", {31'd0, a_ready}, {31'd0, ga});
        chk("b_ready", {31'd0, b_ready}, {31'd0, gb});
        if (ga) last_b_m = 1'b0;
        else if (gb) last_b_m = 1'b1;
        if (ga && !aw) ard_m = mem_m[aad];
        if (gb && !bw) brd_m = mem_m[bad];
        if (ga && aw) mem_m[aad] = ad;
        if (gb && bw) mem_m[bad] = bd;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, ga && !aw});
        chk("a_rdata",  a_rdata, ard_m);
        chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, gb && !bw});
        chk("b_rdata",  b_rdata, brd_m);
    endtask

    // Issue a clear command from IDLE and follow it to completion.
    task automatic do_sweep(input logic [4:0] lo, input logic [4:0] hi);
        logic g1, g2;
        int   n;
        a_valid = 1'b0; b_valid = 1'b0;
        clr_lo = lo; clr_hi = hi; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        if (lo <= hi) begin
            n = int'(hi) - int'(lo) + 1;
            for (int k = 0; k < n; k++) begin
                a_valid = 1'b1; a_wr = 1'($urandom); a_addr = 5'($urandom); a_wdata = $urandom;
                b_valid = 1'b1; b_wr = 1'($urandom); b_addr = 5'($urandom); b_wdata = $urandom;
                // A second start mid-sweep must be ignored.
                clr_start = (k == 1);
                clr_lo = '0; clr_hi = 5'd31;
                #1;
                chk("sw_busy",    {31'd0, clr_busy}, 32'd1);
                chk("sw_a_ready", {31'd0, a_ready},  32'd0);
                chk("sw_b_ready", {31'd0, b_ready},  32'd0);
                chk("sw_done",    {31'd0, clr_done}, 32'd0);
                tick();
                chk("sw_a_rvalid", {31'd0, a_rvalid}, 32'd0);
                chk("sw_b_rvalid", {31'd0, b_rvalid}, 32'd0);
                chk("sw_a_rdata",  a_rdata, ard_m);
            end
            clr_start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
            for (int i = int'(lo); i <= int'(hi); i++) mem_m[i] = '0;
            chk("done_ok",   {31'd0, clr_done}, 32'd1);
            chk("err_ok",    {31'd0, clr_err},  32'd0);
            chk("busy_off",  {31'd0, clr_busy}, 32'd0);
        end else begin
            chk("done_bad",  {31'd0, clr_done}, 32'd1);
            chk("err_bad",   {31'd0, clr_err},  32'd1);
            chk("busy_bad",  {31'd0, clr_busy}, 32'd0);
        end
        // Grants resume in DONE.
        drive_cycle(1'b1, 1'b0, 5'($urandom), '0, 1'b1, 1'b0, 5'($urandom), '0, g1, g2);
        chk("done_pulse", {31'd0, clr_done}, 32'd0);
        chk("err_pulse",  {31'd0, clr_err},  32'd0);
        chk("busy_idle",  {31'd0, clr_busy}, 32'd0);
    endtask

    initial begin
        logic ga, gb;
        int   accepts;
        a_valid = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_valid = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
        clr_start = 0; clr_lo = '0; clr_hi = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk_outputs_zero("rst");
        rst_n = 1'b1;

        // A reads addr 5 after reset
        drive_cycle(1'b1, 1'b0, 5'd5, '0, 1'b0, 1'b0, '0, '0, ga, gb);
        chk("rd5_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("rd5_data",   a_rdata, 32'd0);

        // A writes, B reads back next cycle
        drive_cycle(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, ga, gb);
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd3, '0, ga, gb);
        chk("b_rd3_rvalid", {31'd0, b_rvalid}, 32'd1);
        chk("b_rd3_data",   b_rdata, 32'hDEADBEEF);

        // Fill with index, clear 4..9
        for (int i = 0; i < NUM; i++)
            drive_cycle(1'b1, 1'b1, 5'(i), 32'(i), 1'b0, 1'b0, '0, '0, ga, gb);
        do_sweep(5'd4, 5'd9);
        drive_cycle(1'b1, 1'b0, 5'd3, '0, 1'b0, 1'b0, '0, '0, ga, gb);
        chk("rd3_after_clr", a_rdata, 32'd3);
        drive_cycle(1'b1, 1'b0, 5'd4, '0, 1'b0, 1'b0, '0, '0, ga, gb);
        chk("rd4_after_clr", a_rdata, 32'd0);
        drive_cycle(1'b1, 1'b0, 5'd9, '0, 1'b0, 1'b0, '0, '0, ga, gb);
        chk("rd9_after_clr", a_rdata, 32'd0);
        drive_cycle(1'b1, 1'b0, 5'd10, '0, 1'b0, 1'b0, '0, '0, ga, gb);
        chk("rd10_after_clr", a_rdata, 32'd10);
        for (int i = 0; i < NUM; i++)
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'(i), '0, ga, gb);

        // Rejected bounds, then single-entry clear
        do_sweep(5'd12, 5'd7);
        for (int i = 0; i < NUM; i++)
            drive_cycle(1'b1, 1'b0, 5'(i), '0, 1'b0, 1'b0, '0, '0, ga, gb);
        do_sweep(5'd20, 5'd20);
        for (int i = 19; i <= 21; i++)
            drive_cycle(1'b1, 1'b0, 5'(i), '0, 1'b0, 1'b0, '0, '0, ga, gb);

        // Random traffic and random sweeps
        repeat (300)
            drive_cycle(1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                        1'($urandom), 1'($urandom), 5'($urandom), $urandom, ga, gb);
        repeat (4) begin
            do_sweep(5'($urandom), 5'($urandom));
            repeat (20)
                drive_cycle(1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                            1'($urandom), 1'($urandom), 5'($urandom), $urandom, ga, gb);
        end
        for (int i = 0; i < NUM; i++)
            drive_cycle(1'b1, 1'b0, 5'(i), '0, 1'b1, 1'b0, 5'(NUM - 1 - i), '0, ga, gb);

        // Read accepted alongside sweep start returns pre-clear data; then reset mid-sweep
        for (int i = 0; i < NUM; i++)
            drive_cycle(1'b1, 1'b1, 5'(i), 32'(i), 1'b0, 1'b0, '0, '0, ga, gb);
        a_valid = 1'b1; a_wr = 1'b0; a_addr = 5'd10;
        clr_start = 1'b1; clr_lo = 5'd0; clr_hi = 5'd31;
        #1;
        chk("pre_sweep_rd_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0; clr_start = 1'b0;
        chk("pre_sweep_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("pre_sweep_rdata",  a_rdata, 32'd10);
        chk("pre_sweep_busy",   {31'd0, clr_busy}, 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        tick();
        rst_n = 1'b1;
        model_reset();
        repeat (3) begin
            tick();
            chk("post_rst_busy", {31'd0, clr_busy}, 32'd0);
            chk("post_rst_done", {31'd0, clr_done}, 32'd0);
        end

        // Both ports held valid: strict alternation starting with A
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b1, 5'(i), $urandom, 1'b1, 1'b0, 5'(i + 8), '0, ga, gb);
            chk("alt_a", {31'd0, ga}, {31'd0, (i % 2) == 0});
            chk("alt_b", {31'd0, gb}, {31'd0, (i % 2) == 1});
            accepts += int'(ga) + int'(gb);
        end
        chk("alt_accepts", 32'(accepts), 32'd6);
        for (int i = 0; i < NUM; i++)
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'(i), '0, ga, gb);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
